bcd_display_scan: RTL and testbench

- Downstream of the binary-to-BCD converter. Latches the four BCD digits (millares, centenas, decenas, unidades) when the converter's completion strobe is high.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display, with leading-zero blanking.
- All outputs are registered. Drives board pins directly.

---
 rtl/bcd_display_scan.sv | 143 ++++++++++++++
 tb/tb_bcd_display_scan.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Latches four BCD digits on a strobe and time-multiplexes them onto a 4-digit
// 7-segment display with optional leading-zero blanking. All outputs are registered.
module bcd_display_scan #(
    parameter int unsigned REFRESH_DIV    = 27000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] millares_in,
    input  logic [3:0] centenas_in,
    input  logic [3:0] decenas_in,
    input  logic [3:0] unidades_in,
    input  logic       valid_in,
    output logic [6:0] seg_o,
    output logic [3:0] an_o
);

    localparam int unsigned        PRESC_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'b1111    : 4'b0000;

    localparam logic [1:0] SLOT_UNI  = 2'd0;
    localparam logic [1:0] SLOT_DEC  = 2'd1;
    localparam logic [1:0] SLOT_CEN  = 2'd2;
    localparam logic [1:0] SLOT_MIL  = 2'd3;

    logic [3:0]         mil_q, mil_d;
    logic [3:0]         cen_q, cen_d;
    logic [3:0]         dec_q, dec_d;
    logic [3:0]         uni_q, uni_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               tick;
    logic [3:0]         digit;
    logic               blank;

    // Active-high {g,f,e,d,c,b,a}; codes 10..15 show a dash.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    always_comb begin
        mil_d = mil_q;
        cen_d = cen_q;
        dec_d = dec_q;
        uni_d = uni_q;
        if (valid_in) begin
            mil_d = millares_in;
            cen_d = centenas_in;
            dec_d = decenas_in;
            uni_d = unidades_in;
        end
    end

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
    end

    // Blanking only suppresses zeros to the left of the first nonzero digit.
    always_comb begin
        digit = uni_q;
        blank = 1'b0;
        unique case (idx_q)
            SLOT_UNI: begin
                digit = uni_q;
                blank = 1'b0;
            end
            SLOT_DEC: begin
                digit = dec_q;
                blank = BLANK_LEADING && (mil_q == 4'd0) && (cen_q == 4'd0) && (dec_q == 4'd0);
            end
            SLOT_CEN: begin
                digit = cen_q;
                blank = BLANK_LEADING && (mil_q == 4'd0) && (cen_q == 4'd0);
            end
            SLOT_MIL: begin
                digit = mil_q;
                blank = BLANK_LEADING && (mil_q == 4'd0);
            end
            default: begin
                digit = uni_q;
                blank = 1'b0;
            end
        endcase
    end

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (!blank) begin
            seg_d = seg7(digit) ^ {7{SEG_ACTIVE_LOW}};
            an_d  = (4'b0001 << idx_q) ^ {4{AN_ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mil_q   <= 4'd0;
            cen_q   <= 4'd0;
            dec_q   <= 4'd0;
            uni_q   <= 4'd0;
            presc_q <= '0;
            idx_q   <= SLOT_UNI;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            mil_q   <= mil_d;
            cen_q   <= cen_d;
            dec_q   <= dec_d;
            uni_q   <= uni_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4, active-low pins and blanking on.
module tb_bcd_display_scan;

    typedef struct packed {
        logic [3:0]      m;
        logic [3:0]      c;
        logic [3:0]      d;
        logic [3:0]      u;
        logic [3:0][3:0] an;   // indexed by slot: [0]=units .. [3]=thousands
        logic [3:0][6:0] seg;
    } vec_t;

    localparam logic [3:0]      BA     = 4'b1111;
    localparam logic [6:0]      BS     = 7'b1111111;
    localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] millares_in = 4'd0;
    logic [3:0] centenas_in = 4'd0;
    logic [3:0] decenas_in  = 4'd0;
    logic [3:0] unidades_in = 4'd0;
    logic       valid_in = 1'b0;
    logic [6:0] seg_o;
    logic [3:0] an_o;

    int   total = 0;
    int   bad   = 0;
    int   k     = 0;  // posedges since the last reset edge
    vec_t tbl[9];

    bcd_display_scan #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .millares_in(millares_in),
        .centenas_in(centenas_in),
        .decenas_in (decenas_in),
        .unidades_in(unidades_in),
        .valid_in   (valid_in),
        .seg_o      (seg_o),
        .an_o       (an_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    task automatic check_one(input string name, input logic [3:0] ea, input logic [6:0] es);
        total++;
        if (an_o !== ea || seg_o !== es) begin
            bad++;
            $display("FAIL %s k=%0d an_o=%b seg_o=%b expected an_o=%b seg_o=%b",
                     name, k, an_o, seg_o, ea, es);
        end
    endtask

    task automatic check_cycles(input int t, input int n, input string name);
        int s;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s = ((k - 1) >> 2) & 3;
            check_one(name, tbl[t].an[s], tbl[t].seg[s]);
        end
    endtask

    // One-cycle valid pulse, then scramble the inputs to prove the hold.
    task automatic apply(input int t);
        millares_in = tbl[t].m;
        centenas_in = tbl[t].c;
        decenas_in  = tbl[t].d;
        unidades_in = tbl[t].u;
        valid_in    = 1'b1;
        @(negedge clk);
        valid_in    = 1'b0;
        millares_in = 4'd9;
        centenas_in = 4'd9;
        decenas_in  = 4'd9;
        unidades_in = 4'd9;
    endtask

    initial begin
        tbl[0] = '{4'd0, 4'd0, 4'd0, 4'd0, {BA, BA, BA, 4'b1110}, {BS, BS, BS, 7'b1000000}};
        tbl[1] = '{4'd1, 4'd2, 4'd3, 4'd4, AN_ALL,
                   {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        tbl[2] = '{4'd0, 4'd0, 4'd0, 4'd7, {BA, BA, BA, 4'b1110}, {BS, BS, BS, 7'b1111000}};
        tbl[3] = '{4'd1, 4'd0, 4'd0, 4'd5, AN_ALL,
                   {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010}};
        tbl[4] = '{4'd0, 4'd0, 4'd12, 4'd3, {BA, BA, 4'b1101, 4'b1110},
                   {BS, BS, 7'b0111111, 7'b0110000}};
        tbl[5] = '{4'd9, 4'd8, 4'd6, 4'd0, AN_ALL,
                   {7'b0010000, 7'b0000000, 7'b0000010, 7'b1000000}};
        tbl[6] = '{4'd0, 4'd5, 4'd0, 4'd0, {BA, 4'b1011, 4'b1101, 4'b1110},
                   {BS, 7'b0010010, 7'b1000000, 7'b1000000}};
        tbl[7] = '{4'd15, 4'd0, 4'd0, 4'd0, AN_ALL,
                   {7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000}};
        tbl[8] = '{4'd9, 4'd9, 4'd9, 4'd9, AN_ALL,
                   {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};

        // Reset state, then the first slot shows "0" on units only.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_one("reset", 4'b1111, 7'b1111111);
        end
        rst = 1'b1;
        check_cycles(0, 16, "after_reset");

        for (int t = 1; t <= 7; t++) begin
            apply(t);
            check_cycles(t, 32, $sformatf("scan_vec%0d", t));
        end

        // Hold with changed inputs, then capture on the same edge as tick.
        apply(1);
        check_cycles(1, 16, "hold_1234");
        for (int i = 0; i < 8 && (k % 4) != 3; i++) @(negedge clk);
        millares_in = 4'd9;
        centenas_in = 4'd9;
        decenas_in  = 4'd9;
        unidades_in = 4'd9;
        valid_in    = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check_one("coinc_old", tbl[1].an[((k - 1) >> 2) & 3], tbl[1].seg[((k - 1) >> 2) & 3]);
        check_cycles(8, 16, "coinc_new");

        // Reset while idx==2; a concurrent valid must lose to reset.
        for (int i = 0; i < 32 && (k % 16) != 9; i++) @(negedge clk);
        rst         = 1'b0;
        valid_in    = 1'b1;
        millares_in = 4'd8;
        centenas_in = 4'd8;
        decenas_in  = 4'd8;
        unidades_in = 4'd8;
        @(negedge clk);
        check_one("rst_mid", 4'b1111, 7'b1111111);
        rst      = 1'b1;
        valid_in = 1'b0;
        check_cycles(0, 16, "rst_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
